// File: rtl/spi_sclk_generator.sv
// SPI serial-clock generator: run-time half-period divider, CPOL/CPHA modes and
// fixed-length bursts, with per-edge sample/shift strobes for the shift datapath.
module spi_sclk_generator #(
   parameter int DIV_WIDTH = 8,
   parameter int MAX_BITS  = 32,
   localparam int CNT_W    = $clog2(MAX_BITS + 1)
) (
   input  logic                 clkIn,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DIV_WIDTH-1:0] halfDiv,
   input  logic [CNT_W-1:0]     numBits,
   input  logic                 cpol,
   input  logic                 cpha,
   output logic                 sclk,
   output logic                 busy,
   output logic                 done,
   output logic                 sampleStrobe,
   output logic                 shiftStrobe
);

   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

   state_t               state;
   logic [DIV_WIDTH-1:0] h_q;
   logic [CNT_W-1:0]     n_q;
   logic                 cpol_q;
   logic                 cpha_q;
   logic [DIV_WIDTH-1:0] hcnt;
   logic [CNT_W:0]       edge_cnt;

   logic [DIV_WIDTH-1:0] h_in;
   logic [CNT_W-1:0]     n_in;
   logic [DIV_WIDTH-1:0] h_last;
   logic [CNT_W:0]       two_n;
   logic [CNT_W:0]       edge_nxt;
   logic                 half_end;

   assign h_in     = (halfDiv == '0) ? DIV_WIDTH'(1) : halfDiv;
   assign n_in     = (numBits > CNT_W'(MAX_BITS)) ? CNT_W'(MAX_BITS) : numBits;
   assign h_last   = h_q - DIV_WIDTH'(1);
   assign two_n    = {n_q, 1'b0};
   assign edge_nxt = edge_cnt + (CNT_W + 1)'(1);
   assign half_end = (hcnt == h_last);

   always_ff @(posedge clkIn or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         h_q          <= DIV_WIDTH'(1);
         n_q          <= '0;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         hcnt         <= '0;
         edge_cnt     <= '0;
         sclk         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sampleStrobe <= 1'b0;
         shiftStrobe  <= 1'b0;
      end else begin
         done         <= 1'b0;
         sampleStrobe <= 1'b0;
         shiftStrobe  <= 1'b0;
         if (abort) begin
            // abort outranks everything, including a start seen in IDLE
            state    <= IDLE;
            sclk     <= cpol_q;
            busy     <= 1'b0;
            hcnt     <= '0;
            edge_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  sclk <= cpol;
                  if (start) begin
                     h_q      <= h_in;
                     n_q      <= n_in;
                     cpol_q   <= cpol;
                     cpha_q   <= cpha;
                     hcnt     <= '0;
                     edge_cnt <= '0;
                     busy     <= 1'b1;
                     state    <= (n_in == '0) ? TAIL : RUN;
                  end
               end
               RUN: begin
                  if (half_end) begin
                     hcnt     <= '0;
                     sclk     <= ~sclk;
                     edge_cnt <= edge_nxt;
                     // odd edges lead, even edges trail; the final trailing edge never shifts
                     if (edge_nxt[0]) begin
                        if (cpha_q) shiftStrobe  <= 1'b1;
                        else        sampleStrobe <= 1'b1;
                     end else begin
                        if (cpha_q)                   sampleStrobe <= 1'b1;
                        else if (edge_nxt != two_n)   shiftStrobe  <= 1'b1;
                     end
                     if (edge_nxt == two_n) state <= TAIL;
                  end else begin
                     hcnt <= hcnt + DIV_WIDTH'(1);
                  end
               end
               TAIL: begin
                  sclk <= cpol_q;
                  if (half_end) begin
                     hcnt  <= '0;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     hcnt <= hcnt + DIV_WIDTH'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
